// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue: a DEPTH-entry FIFO of PC/instruction pairs
// with a synchronous flush for branch/jump redirects and zeroed outputs when empty.
module fetch_decode_queue #(
    parameter int PCW    = 32,
    parameter int INSTRW = 16,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PCW-1:0]             PC_in,
    input  logic [INSTRW-1:0]          instr_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PCW-1:0]             PC_out,
    output logic [INSTRW-1:0]          instr_out,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Handshake: a transfer happens on a rising edge where valid && ready && !flush;
    // ready never depends combinationally on the other side's valid or ready.
    logic [PCW-1:0]    pc_mem    [DEPTH];
    logic [INSTRW-1:0] instr_mem [DEPTH];
    logic [AW-1:0]     head;
    logic [AW-1:0]     tail;
    logic              push;
    logic              pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready && !flush && !rst;
    assign pop       = out_valid && out_ready && !flush;

    // Gate the head entry so stale storage never reaches decode.
    assign PC_out    = out_valid ? pc_mem[head]    : '0;
    assign instr_out = out_valid ? instr_mem[head] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail]    <= PC_in;
            instr_mem[tail] <= instr_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + AW'(1);
            if (pop)  head <= head + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue: a queue-based reference model checked
// against the DUT every cycle, plus literal expectations for the key scenarios.
module tb_fetch_decode_queue;
    localparam int PCW    = 32;
    localparam int INSTRW = 16;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int W      = PCW + INSTRW;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [PCW-1:0]    PC_in = '0;
    logic [INSTRW-1:0] instr_in = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [PCW-1:0]    PC_out;
    logic [INSTRW-1:0] instr_out;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;

    int checks = 0;
    int errors = 0;
    int pops_total = 0;

    logic [W-1:0] exp_q[$];

    fetch_decode_queue #(.PCW(PCW), .INSTRW(INSTRW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .PC_in(PC_in), .instr_in(instr_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .PC_out(PC_out), .instr_out(instr_out),
        .count(count), .full(full), .empty(empty)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic logic [INSTRW-1:0] instr_of(input logic [PCW-1:0] pc);
        return pc[INSTRW-1:0] ^ 16'h5A3C;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: FIFO of {pc, instr}; push judged on the occupancy before the edge
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
        end else if (flush) begin
            exp_q.delete();
        end else begin
            logic do_push;
            logic do_pop;
            do_push = in_valid && (exp_q.size() < DEPTH);
            do_pop  = out_ready && (exp_q.size() > 0);
            if (do_pop) begin
                void'(exp_q.pop_front());
                pops_total++;
            end
            if (do_push) exp_q.push_back({PC_in, instr_in});
        end
    end

    // scoreboard compare, every falling edge
    always @(negedge clk) begin
        logic [W-1:0] head_e;
        int sz;
        sz = exp_q.size();
        head_e = (sz > 0) ? exp_q[0] : '0;
        chk("out_valid", 64'(out_valid), 64'(sz > 0));
        chk("PC_out",    64'(PC_out),    64'(head_e[W-1:INSTRW]));
        chk("instr_out", 64'(instr_out), 64'(head_e[INSTRW-1:0]));
        chk("count",     64'(count),     64'(sz));
        chk("full",      64'(full),      64'(sz == DEPTH));
        chk("empty",     64'(empty),     64'(sz == 0));
        chk("in_ready",  64'(in_ready),  64'(sz != DEPTH));
    end

    // driver: inputs change 1 time unit after the falling edge
    task automatic cycle(input logic v, input logic [PCW-1:0] pc, input logic rdy, input logic fl);
        @(negedge clk);
        #1;
        in_valid  = v;
        PC_in     = pc;
        instr_in  = instr_of(pc);
        out_ready = rdy;
        flush     = fl;
    endtask

    initial begin
        int pops_before;
        // reset state
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_empty",     64'(empty),     64'd1);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        // fill then drain
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h100 + 32'(2 * i), 1'b0, 1'b0);
        cycle(1'b1, 32'h108, 1'b0, 1'b0);
        chk("fill_full",     64'(full),     64'd1);
        chk("fill_in_ready", 64'(in_ready), 64'd0);
        chk("fill_count",    64'(count),    64'd4);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("fill_5th_ignored", 64'(count),  64'd4);
        chk("drain_pc0",        64'(PC_out), 64'h100);
        chk("drain_instr0",     64'(instr_out), 64'(16'h0100 ^ 16'h5A3C));
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("drain_pc1", 64'(PC_out), 64'h102);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("drain_pc2", 64'(PC_out), 64'h104);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("drain_pc3", 64'(PC_out), 64'h106);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("drain_empty",  64'(empty),  64'd1);
        chk("drain_pc_zero", 64'(PC_out), 64'd0);

        // streaming: 16 pairs wrap the 4-entry pointers four times
        pops_before = pops_total;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 32'h300 + 32'(2 * i), 1'b1, 1'b0);
            if (i >= 2) begin
                chk("stream_count", 64'(count),  64'd1);
                chk("stream_pc",    64'(PC_out), 64'(32'h300 + 32'(2 * (i - 1))));
            end
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("stream_pops", 64'(pops_total - pops_before), 64'd16);
        chk("stream_empty", 64'(empty), 64'd1);

        // flush with concurrent push, then a held flush
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h180 + 32'(2 * i), 1'b0, 1'b0);
        cycle(1'b1, 32'h200, 1'b0, 1'b1);
        chk("pre_flush_count", 64'(count), 64'd3);
        cycle(1'b1, 32'h210, 1'b1, 1'b1);
        chk("flush_count",     64'(count),     64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        cycle(1'b1, 32'h212, 1'b1, 1'b1);
        chk("flush_hold_ready", 64'(in_ready), 64'd1);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("flush_hold_empty", 64'(empty),  64'd1);
        chk("flush_no_200",     64'(PC_out), 64'd0);

        // full with pop: the blocked pair must never be enqueued
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h400 + 32'(2 * i), 1'b0, 1'b0);
        cycle(1'b1, 32'h4F0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("fullpop_count", 64'(count),  64'd3);
        chk("fullpop_head",  64'(PC_out), 64'h402);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        chk("fullpop_drained", 64'(empty), 64'd1);

        // asynchronous reset mid-operation
        cycle(1'b1, 32'h500, 1'b0, 1'b0);
        cycle(1'b1, 32'h502, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("pre_rst_count", 64'(count), 64'd2);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_pc",        64'(PC_out),    64'd0);
        chk("arst_instr",     64'(instr_out), 64'd0);
        chk("arst_count",     64'(count),     64'd0);
        cycle(1'b1, 32'h600, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        chk("rst_push_ignored", 64'(count), 64'd0);
        rst = 1'b0;
        in_valid = 1'b1;
        PC_in = 32'h602;
        instr_in = instr_of(32'h602);
        out_ready = 1'b0;
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_pc",    64'(PC_out),    64'h602);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("final_empty", 64'(empty), 64'd1);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
